// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the pipelined ALU
package alu_pkg;

   localparam logic [3:0] OP_INC  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUBB = 4'b0010;
   localparam logic [3:0] OP_DEC  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SHR  = 4'b1000;
   localparam logic [3:0] OP_SHL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_ROR  = 4'b1011;

   localparam int FLG_N   = 3;
   localparam int FLG_Z   = 2;
   localparam int FLG_V   = 1;
   localparam int FLG_ERR = 0;

endpackage

// File: rtl/alu_exec.sv
// alu_exec: combinational ALU core (arith, logic, shifts, rotate); flags only with ALU_FLAGS_EN
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] f,
   output logic             cout
`ifdef ALU_FLAGS_EN
   ,output logic [3:0]      flags
`endif
);

   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shr;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   sra;
   logic [WIDTH-1:0] ror;

   // second adder operand: 0 for inc, B, ~B for subtract-with-borrow, all-ones for dec
   assign opb = (sel == OP_INC) ? '0 : (sel == OP_ADD) ? b : (sel == OP_SUBB) ? ~b : '1;
   assign sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
   // a guard bit below/above the operand catches the last bit shifted out (0 when shamt is 0)
   assign shr = {a, 1'b0} >> shamt;
   assign shl = {1'b0, a} << shamt;
   assign sra = $signed({a, 1'b0}) >>> shamt;
   assign ror = (a >> shamt) | (a << (WIDTH - int'(shamt)));

   // opcode select; cin only reaches the result through the arithmetic branch
   always_comb begin
      f    = '0;
      cout = 1'b0;
      case (sel)
         OP_INC, OP_ADD, OP_SUBB, OP_DEC: begin
            f    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         OP_AND: f = a & b;
         OP_OR:  f = a | b;
         OP_XOR: f = a ^ b;
         OP_NOT: f = ~a;
         OP_SHR: begin
            f    = shr[WIDTH:1];
            cout = shr[0];
         end
         OP_SHL: begin
            f    = shl[WIDTH-1:0];
            cout = shl[WIDTH];
         end
         OP_SRA: begin
            f    = sra[WIDTH:1];
            cout = sra[0];
         end
         OP_ROR: begin
            f    = ror;
            cout = ror[WIDTH-1];
         end
         default: ;
      endcase
   end

`ifdef ALU_FLAGS_EN
   // status flags; overflow only meaningful for the adder opcodes 0000-0011
   always_comb begin
      flags          = '0;
      flags[FLG_N]   = f[WIDTH-1];
      flags[FLG_Z]   = (f == '0);
      flags[FLG_V]   = (sel[3:2] == 2'b00) && (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      flags[FLG_ERR] = (sel[3:2] == 2'b11);
   end
`endif

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU; flags_o port and flag registers only with ALU_FLAGS_EN
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic [3:0]       sel_i,
   input  logic [SHW-1:0]   shamt_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] f_o,
   output logic             cout_o
`ifdef ALU_FLAGS_EN
   ,output logic [3:0]      flags_o
`endif
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_cin;
   logic [3:0]       s1_sel;
   logic [SHW-1:0]   s1_shamt;
   logic             s2_valid;
   logic             s2_load;
   logic [WIDTH-1:0] x_f;
   logic             x_cout;
`ifdef ALU_FLAGS_EN
   logic [3:0]       x_flags;
`endif

   // S2 can take a new result when empty or when its current result leaves this cycle
   assign s2_load = !s2_valid || ready_i;
   assign ready_o = !s1_valid || s2_load;
   assign valid_o = s2_valid;

   alu_exec #(.WIDTH(WIDTH), .SHW(SHW)) u_exec (
      .a     (s1_a),
      .b     (s1_b),
      .cin   (s1_cin),
      .sel   (s1_sel),
      .shamt (s1_shamt),
      .f     (x_f),
      .cout  (x_cout)
`ifdef ALU_FLAGS_EN
      ,.flags(x_flags)
`endif
   );

   // S1: operand register, refilled (or emptied) whenever it is free or moving into S2
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_cin   <= 1'b0;
         s1_sel   <= '0;
         s1_shamt <= '0;
      end else if (ready_o) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_a     <= a_i;
            s1_b     <= b_i;
            s1_cin   <= cin_i;
            s1_sel   <= sel_i;
            s1_shamt <= shamt_i;
         end
      end
   end

   // S2: result register; holds steady while the output is stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         f_o      <= '0;
         cout_o   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            f_o    <= x_f;
            cout_o <= x_cout;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   // S2 flags, loaded in lockstep with the result
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) flags_o <= '0;
      else if (s2_load && s1_valid) flags_o <= x_flags;
   end
`endif

endmodule
